vga_timing_pipe: RTL and testbench
==================================

// Module: vga_timing_pipe
// PURPOSE
// - Parametrised VGA raster generator; next generation of the snake display controller.
// - Single clock domain: both h and v counters run on i_clock, with no derived sync clock.
// - Issues pixel coordinates to the entity lookup, then realigns sync/DE with the returned
//   entity over LOOKUP_LAT cycles and drives registered RGB/HS/VS pins.
// - Sits between the game-board entity RAM/lookup and the board VGA connector; o_frame_start paces game ticks.
// PARAMETERS
// - H_ACTIVE 640, H_FRONT 16, H_SYNC 96, H_BACK 48 : horizontal timing in clocks.
// - V_ACTIVE 480, V_FRONT 10, V_SYNC 2, V_BACK 33 : vertical timing in lines.
// - COORD_W 10 : width of coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1.
// - COLOR_W 4 : bits per colour channel.
// - ENTITY_W 2 : width of entity code.
// - LOOKUP_LAT 1 : clocks from coordinate issue to valid i_entity; range 0..4.
// - HS_ACTIVE_LOW 1, VS_ACTIVE_LOW 1 : sync polarity; 1 = pulse low.
// PORTS
// - i_clock          in   1         pixel clock
// - i_reset          in   1         synchronous, active-high reset
// - i_entity         in   ENTITY_W  entity at the coordinate issued LOOKUP_LAT clocks earlier
// - o_curr_x         out  COORD_W   active-area x of issued pixel; 0 in blanking
// - o_curr_y         out  COORD_W   active-area y of issued pixel; 0 in blanking
// - o_req_valid      out  1         issued coordinate is inside the active area
// - o_frame_start    out  1         1-clock pulse when counters are at (0,0)
// - o_vga_r/g/b      out  COLOR_W   registered colour
// - o_vga_hs, o_vga_vs out 1        registered syncs
// - o_vga_de         out  1         registered data enable
// BEHAVIOUR
// - H_BLANK = H_FRONT+H_SYNC+H_BACK; H_TOTAL = H_BLANK+H_ACTIVE. V_BLANK and V_TOTAL are defined likewise.
// - Line order is blank-first: front porch, sync, back porch, then active. The same order applies vertically.
// - h_count runs 0..H_TOTAL-1 and wraps to 0. v_count increments only on the h wrap and wraps at V_TOTAL-1.
// - Stage S0 (counter state) is combinational from the counters:
//   - o_req_valid = (h_count >= H_BLANK) && (v_count >= V_BLANK).
//   - When valid, o_curr_x = h_count - H_BLANK and o_curr_y = v_count - V_BLANK; otherwise both are 0.
//   - hs_raw = h_count in [H_FRONT, H_FRONT+H_SYNC-1]; vs_raw = v_count in [V_FRONT, V_FRONT+V_SYNC-1].
//   - vs_raw is evaluated on the whole line, so VS edges coincide with h_count = 0.
// - Delay pipe: {hs_raw, vs_raw, req_valid} is shifted through LOOKUP_LAT registers.
//   - LOOKUP_LAT = 0 means no registers; i_entity is then combinational on o_curr_x/o_curr_y in the same clock.
// - Output register is loaded at the end of pipe stage LOOKUP_LAT:
//   - de = piped valid.
//   - rgb = de ? palette(i_entity) : 0.
//   - hs/vs = piped raw XOR ACTIVE_LOW.
//   - Pin latency is LOOKUP_LAT+1 clocks after S0 for every pin.
// - Pixel x = 0 is coloured. The legacy blanking of column 0 is removed.
// - Palette:
//   - NOTHING = all channels max.
//   - SNAKE = green max.
//   - WALL = blue max.
//   - APPLE = red max.
//   - Any other code = 0.
// - o_frame_start = (h_count == 0 && v_count == 0) && !i_reset. It is not delayed.
// - Reset, including mid-frame:
//   - Counters go to 0 and all pipe stages clear to inactive (valid = 0, syncs inactive).
//   - Pins: rgb = 0, de = 0, hs/vs at their inactive level.
//   - The first clock after release is h_count = 0, v_count = 0, so o_frame_start = 1.
//   - Garbage from the pre-reset frame never reaches the pins.
// - i_entity is ignored (no effect) whenever the piped valid is 0.
// STRUCTURE
// - Package vga_pkg holds:
//   - timing defaults as localparams;
//   - the entity_t enum (NOTHING, SNAKE, WALL, APPLE), replacing the define.vh macros;
//   - the palette function entity_to_rgb().
// - Sub-module vga_axis_counter (params TOTAL, FRONT, SYNC, BLANK; inputs i_clock, i_reset, i_step):
//   - Outputs count, wrap, sync_raw and active.
//   - Instantiated twice: h with i_step = 1; v with i_step = h wrap.
// - Top level holds the generate-based delay pipe and the output register.
// TESTING (default timing)
// 1. Release reset:
//    - o_frame_start = 1 on the first clock after release.
//    - o_vga_hs goes low LOOKUP_LAT+1 clocks after h_count = 16 and stays low for exactly 96 clocks.
// 2. Free run for 2 frames:
//    - HS period is 800 clocks.
//    - VS is low for 1600 clocks.
//    - o_frame_start repeats every 420000 clocks.
//    - o_vga_de is high for 640 clocks per line and 480 lines per frame.
// 3. Coordinates:
//    - h = 160, v = 45 gives x = 0, y = 0, valid = 1.
//    - h = 799, v = 524 gives x = 639, y = 479.
//    - h = 159 gives x = 0, y = 0, valid = 0.
// 4. LOOKUP_LAT = 2; model returns SNAKE only for request (5,0) and NOTHING elsewhere:
//    - Pins show g = F, r = b = 0 for exactly one clock, 3 clocks after that request.
//    - Neighbouring pixels are F/F/F.
// 5. i_entity held at APPLE:
//    - rgb = 0 whenever o_vga_de = 0.
//    - Column x = 0 shows r = F.
// 6. Assert i_reset for 1 clock at h = 300, v = 200:
//    - On the next clock rgb = 0, de = 0, syncs inactive.
//    - Counters restart at (0,0) with o_frame_start = 1.
//    - No stale pixel appears within the following LOOKUP_LAT+1 clocks.
// 7. HS_ACTIVE_LOW = 0: HS pulses high for 96 clocks at the same position as in test 1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA raster pipeline:
//   - default timing values (640x480 @ 60 Hz, 25 MHz class pixel clock)
//   - entity_t, the codes returned by the game-board entity lookup
//   - pipe_t, the per-pixel control word carried through the lookup delay pipe
//   - entity_to_rgb(), the palette
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        SNAKE   = 2'd1,
        WALL    = 2'd2,
        APPLE   = 2'd3
    } entity_t;

    // Raw (polarity-free) syncs and the active-area flag for one pixel.
    typedef struct packed {
        logic hs;
        logic vs;
        logic vld;
    } pipe_t;

    // Palette. Returns {red_max, green_max, blue_max}; the caller replicates
    // each flag across the channel width. The code is widened to 32 bits so
    // that codes outside entity_t (wider ENTITY_W) fall into the black default.
    function automatic logic [2:0] entity_to_rgb(input logic [31:0] code);
        logic [2:0] rgb;
        case (code)
            32'(NOTHING): rgb = 3'b111;
            32'(SNAKE):   rgb = 3'b010;
            32'(WALL):    rgb = 3'b001;
            32'(APPLE):   rgb = 3'b100;
            default:      rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_pipe_if.sv
// vga_timing_pipe_if
// Coordinate request / entity response link between the raster generator
// and the game-board entity lookup.
//   curr_x, curr_y : active-area coordinate of the issued pixel (0 in blanking)
//   req_valid      : issued coordinate lies in the active area
//   entity         : entity code for the coordinate issued LOOKUP_LAT clocks earlier
// Modports: master = raster generator, slave = entity lookup.
interface vga_timing_pipe_if #(
    parameter int COORD_W  = 10,
    parameter int ENTITY_W = 2
);
    logic [COORD_W-1:0]  curr_x;
    logic [COORD_W-1:0]  curr_y;
    logic                req_valid;
    logic [ENTITY_W-1:0] entity;

    modport master (output curr_x, output curr_y, output req_valid, input entity);
    modport slave  (input curr_x, input curr_y, input req_valid, output entity);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis (horizontal or vertical). The axis is ordered blank-first:
// front porch, sync, back porch, then active.
// Ports:
//   i_clock, i_reset : pixel clock, synchronous active-high reset
//   i_step           : advance the count this clock
//   o_count          : position 0..TOTAL-1
//   o_wrap           : stepping from TOTAL-1 back to 0 this clock
//   o_sync_raw       : position inside the sync pulse (polarity-free)
//   o_active         : position inside the active region
module vga_axis_counter #(
    parameter int TOTAL   = 800,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BLANK   = 160,
    parameter int COUNT_W = 10
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_step,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_wrap,
    output logic               o_sync_raw,
    output logic               o_active
);
    import vga_pkg::*;

    localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_FIRST = COUNT_W'(FRONT);
    localparam logic [COUNT_W-1:0] SYNC_LAST  = COUNT_W'(FRONT + SYNC - 1);
    localparam logic [COUNT_W-1:0] ACT_FIRST  = COUNT_W'(BLANK);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    assign o_wrap = i_step && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (i_step) begin
            count_d = o_wrap ? '0 : count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count    = count_q;
    assign o_sync_raw = (count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST);
    assign o_active   = (count_q >= ACT_FIRST);

endmodule

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe
// VGA raster generator for the snake display. The counters issue a pixel
// coordinate to the entity lookup (stage S0); the syncs and active flag are
// delayed by LOOKUP_LAT registers so they line up with the returned entity,
// and everything is then captured in one output register driving the pins.
// Every pin therefore lags the counters by LOOKUP_LAT+1 clocks.
// Ports:
//   i_clock, i_reset      : pixel clock, synchronous active-high reset
//   lkp (master)          : coordinate request / entity response
//   o_frame_start         : 1-clock pulse while the counters sit at (0,0)
//   o_vga_r/g/b           : registered colour
//   o_vga_hs, o_vga_vs    : registered syncs (polarity per *_ACTIVE_LOW)
//   o_vga_de              : registered data enable
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int H_FRONT       = H_FRONT_DEF,
    parameter int H_SYNC        = H_SYNC_DEF,
    parameter int H_BACK        = H_BACK_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int V_FRONT       = V_FRONT_DEF,
    parameter int V_SYNC        = V_SYNC_DEF,
    parameter int V_BACK        = V_BACK_DEF,
    parameter int COORD_W       = 10,
    parameter int COLOR_W       = 4,
    parameter int ENTITY_W      = 2,
    parameter int LOOKUP_LAT    = 1,
    parameter int HS_ACTIVE_LOW = 1,
    parameter int VS_ACTIVE_LOW = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    vga_timing_pipe_if.master  lkp,
    output logic               o_frame_start,
    output logic [COLOR_W-1:0] o_vga_r,
    output logic [COLOR_W-1:0] o_vga_g,
    output logic [COLOR_W-1:0] o_vga_b,
    output logic               o_vga_hs,
    output logic               o_vga_vs,
    output logic               o_vga_de
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;

    // Level of each sync pin outside its pulse.
    localparam logic HS_IDLE = (HS_ACTIVE_LOW != 0);
    localparam logic VS_IDLE = (VS_ACTIVE_LOW != 0);

    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               h_wrap;
    logic               h_sync_raw;
    logic               v_sync_raw;
    logic               h_active;
    logic               v_active;
    logic               req_valid;
    pipe_t              s0;
    pipe_t              piped;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .FRONT(H_FRONT), .SYNC(H_SYNC), .BLANK(H_BLANK), .COUNT_W(COORD_W)
    ) u_h_counter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_step     (1'b1),
        .o_count    (h_count),
        .o_wrap     (h_wrap),
        .o_sync_raw (h_sync_raw),
        .o_active   (h_active)
    );

    // The vertical axis steps on the horizontal wrap, so vs_raw holds for the
    // whole line and VS edges land on h_count = 0.
    vga_axis_counter #(
        .TOTAL(V_TOTAL), .FRONT(V_FRONT), .SYNC(V_SYNC), .BLANK(V_BLANK), .COUNT_W(COORD_W)
    ) u_v_counter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_step     (h_wrap),
        .o_count    (v_count),
        .o_wrap     (),
        .o_sync_raw (v_sync_raw),
        .o_active   (v_active)
    );

    // ---- S0: coordinate issue, combinational from the counters ----
    assign req_valid     = h_active && v_active;
    assign lkp.req_valid = req_valid;
    assign lkp.curr_x    = req_valid ? (h_count - COORD_W'(H_BLANK)) : '0;
    assign lkp.curr_y    = req_valid ? (v_count - COORD_W'(V_BLANK)) : '0;
    assign s0            = {h_sync_raw, v_sync_raw, req_valid};

    // Masked during reset so the pulse first appears on the clock after release.
    assign o_frame_start = (h_count == '0) && (v_count == '0) && !i_reset;

    // ---- S1..S<LOOKUP_LAT>: align control with the lookup latency ----
    generate
        if (LOOKUP_LAT == 0) begin : g_no_pipe
            assign piped = s0;
        end else begin : g_pipe
            pipe_t pipe_q [LOOKUP_LAT];

            // Clearing every stage keeps pre-reset pixels off the pins.
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    for (int i = 0; i < LOOKUP_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= s0;
                    for (int i = 1; i < LOOKUP_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign piped = pipe_q[LOOKUP_LAT-1];
        end
    endgenerate

    // ---- Output register ----
    logic [2:0]         rgb_max;
    logic [COLOR_W-1:0] r_d, g_d, b_d;
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic               hs_d, vs_d, de_d;
    logic               hs_q, vs_q, de_q;

    always_comb begin
        rgb_max = entity_to_rgb(32'(lkp.entity));
        de_d    = piped.vld;
        // i_entity only matters inside the active area.
        r_d     = (de_d && rgb_max[2]) ? '1 : '0;
        g_d     = (de_d && rgb_max[1]) ? '1 : '0;
        b_d     = (de_d && rgb_max[0]) ? '1 : '0;
        hs_d    = piped.hs ^ HS_IDLE;
        vs_d    = piped.vs ^ VS_IDLE;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_q <= 1'b0;
            hs_q <= HS_IDLE;
            vs_q <= VS_IDLE;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign o_vga_r  = r_q;
    assign o_vga_g  = g_q;
    assign o_vga_b  = b_q;
    assign o_vga_de = de_q;
    assign o_vga_hs = hs_q;
    assign o_vga_vs = vs_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
module tb_vga_timing_pipe;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    // ---------------- Instance A: default timing, LOOKUP_LAT = 1 ----------------
    vga_timing_pipe_if #(.COORD_W(10), .ENTITY_W(2)) ifa ();
    logic [1:0] ent_a = 2'd3;
    assign ifa.entity = ent_a;
    logic       fs_a, hs_a, vs_a, de_a;
    logic [3:0] r_a, g_a, b_a;

    vga_timing_pipe dut_a (
        .i_clock(clk), .i_reset(rst_a), .lkp(ifa), .o_frame_start(fs_a),
        .o_vga_r(r_a), .o_vga_g(g_a), .o_vga_b(b_a),
        .o_vga_hs(hs_a), .o_vga_vs(vs_a), .o_vga_de(de_a)
    );

    // ---------------- Instance B: small raster, LOOKUP_LAT = 2 ----------------
    // H: front 2, sync 3, back 2, active 8 (total 15); V: 1, 2, 1, 4 (total 8).
    vga_timing_pipe_if #(.COORD_W(10), .ENTITY_W(2)) ifb ();
    logic       fs_b, hs_b, vs_b, de_b;
    logic [3:0] r_b, g_b, b_b;
    logic [9:0] bx1 = '0, by1 = '0, bx2 = '0, by2 = '0;
    logic       bv1 = 1'b0, bv2 = 1'b0;

    // Two-clock lookup model: SNAKE only at (5,0), NOTHING elsewhere.
    always @(posedge clk) begin
        bx1 <= ifb.curr_x; by1 <= ifb.curr_y; bv1 <= ifb.req_valid;
        bx2 <= bx1;        by2 <= by1;        bv2 <= bv1;
    end
    assign ifb.entity = (bv2 && bx2 == 10'd5 && by2 == 10'd0) ? 2'd1 : 2'd0;

    vga_timing_pipe #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .LOOKUP_LAT(2)
    ) dut_b (
        .i_clock(clk), .i_reset(rst_b), .lkp(ifb), .o_frame_start(fs_b),
        .o_vga_r(r_b), .o_vga_g(g_b), .o_vga_b(b_b),
        .o_vga_hs(hs_b), .o_vga_vs(vs_b), .o_vga_de(de_b)
    );

    // ------- Instance C: default H, small V, LOOKUP_LAT = 0, active-high syncs -------
    vga_timing_pipe_if #(.COORD_W(10), .ENTITY_W(2)) ifc ();
    logic       fs_c, hs_c, vs_c, de_c;
    logic [3:0] r_c, g_c, b_c;
    // Combinational lookup: APPLE in column 0, WALL elsewhere.
    assign ifc.entity = (ifc.req_valid && ifc.curr_x == 10'd0) ? 2'd3 : 2'd2;

    vga_timing_pipe #(
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .LOOKUP_LAT(0), .HS_ACTIVE_LOW(0), .VS_ACTIVE_LOW(0)
    ) dut_c (
        .i_clock(clk), .i_reset(rst_c), .lkp(ifc), .o_frame_start(fs_c),
        .o_vga_r(r_c), .o_vga_g(g_c), .o_vga_b(b_c),
        .o_vga_hs(hs_c), .o_vga_vs(vs_c), .o_vga_de(de_c)
    );

    int cyc_a = 0;

    // Reset state of A, then first clock after release.
    task automatic test_reset();
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({r_a, g_a, b_a, de_a, hs_a, vs_a, fs_a} !== {12'h000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_pins got rgb=%h de=%b hs=%b vs=%b fs=%b want rgb=000 de=0 hs=1 vs=1 fs=0",
                     {r_a, g_a, b_a}, de_a, hs_a, vs_a, fs_a);
        end
        @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);
        cyc_a = 0;
        n_tests++;
        if ({fs_a, ifa.req_valid, ifa.curr_x, ifa.curr_y} !== {1'b1, 1'b0, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL release_frame_start got fs=%b vld=%b x=%0d y=%0d want fs=1 vld=0 x=0 y=0",
                     fs_a, ifa.req_valid, ifa.curr_x, ifa.curr_y);
        end
    endtask

    // Free run of A through line 46, x=299: syncs, DE, coordinates, APPLE colour.
    task automatic test_line_timing();
        int hs_fall1 = -1, hs_fall2 = -1, hs_low_l0 = 0;
        int vs_fall1 = -1, vs_low = 0;
        int de_early = 0, de_l45 = 0, bad_blank = 0, fs_extra = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        while (cyc_a < 46 * 800 + 299) begin
            @(negedge clk);
            cyc_a++;
            if (prev_hs && !hs_a) begin
                if (hs_fall1 < 0) hs_fall1 = cyc_a;
                else if (hs_fall2 < 0) hs_fall2 = cyc_a;
            end
            if (prev_vs && !vs_a && vs_fall1 < 0) vs_fall1 = cyc_a;
            prev_hs = hs_a;
            prev_vs = vs_a;
            if (!hs_a && cyc_a < 800) hs_low_l0++;
            if (!vs_a) vs_low++;
            if (de_a && cyc_a < 45 * 800 + 2) de_early++;
            if (de_a && cyc_a >= 45 * 800 + 2 && cyc_a < 46 * 800 + 2) de_l45++;
            if (!de_a && {r_a, g_a, b_a} != 12'h000) bad_blank++;
            if (fs_a) fs_extra++;
            if (cyc_a == 36159) begin
                n_tests++;
                if ({ifa.req_valid, ifa.curr_x, ifa.curr_y} !== {1'b0, 10'd0, 10'd0}) begin
                    n_fail++;
                    $display("FAIL coord_h159 got vld=%b x=%0d y=%0d want vld=0 x=0 y=0",
                             ifa.req_valid, ifa.curr_x, ifa.curr_y);
                end
            end
            if (cyc_a == 36160) begin
                n_tests++;
                if ({ifa.req_valid, ifa.curr_x, ifa.curr_y} !== {1'b1, 10'd0, 10'd0}) begin
                    n_fail++;
                    $display("FAIL coord_h160_v45 got vld=%b x=%0d y=%0d want vld=1 x=0 y=0",
                             ifa.req_valid, ifa.curr_x, ifa.curr_y);
                end
            end
            if (cyc_a == 36799) begin
                n_tests++;
                if ({ifa.req_valid, ifa.curr_x, ifa.curr_y} !== {1'b1, 10'd639, 10'd0}) begin
                    n_fail++;
                    $display("FAIL coord_h799 got vld=%b x=%0d y=%0d want vld=1 x=639 y=0",
                             ifa.req_valid, ifa.curr_x, ifa.curr_y);
                end
            end
            if (cyc_a == 36161) begin
                n_tests++;
                if ({de_a, r_a, g_a, b_a} !== {1'b0, 12'h000}) begin
                    n_fail++;
                    $display("FAIL pin_before_x0 got de=%b rgb=%h want de=0 rgb=000", de_a, {r_a, g_a, b_a});
                end
            end
            if (cyc_a == 36162) begin
                n_tests++;
                if ({de_a, r_a, g_a, b_a} !== {1'b1, 12'hF00}) begin
                    n_fail++;
                    $display("FAIL pin_x0_apple got de=%b rgb=%h want de=1 rgb=f00", de_a, {r_a, g_a, b_a});
                end
            end
        end
        n_tests++;
        if (hs_fall1 != 18 || hs_low_l0 != 96) begin
            n_fail++;
            $display("FAIL hs_first_pulse got fall=%0d low=%0d want fall=18 low=96", hs_fall1, hs_low_l0);
        end
        n_tests++;
        if (hs_fall2 - hs_fall1 != 800) begin
            n_fail++;
            $display("FAIL hs_period got %0d want 800", hs_fall2 - hs_fall1);
        end
        n_tests++;
        if (vs_fall1 != 8002 || vs_low != 1600) begin
            n_fail++;
            $display("FAIL vs_pulse got fall=%0d low=%0d want fall=8002 low=1600", vs_fall1, vs_low);
        end
        n_tests++;
        if (de_early != 0 || de_l45 != 640) begin
            n_fail++;
            $display("FAIL de_line got early=%0d line45=%0d want early=0 line45=640", de_early, de_l45);
        end
        n_tests++;
        if (bad_blank != 0 || fs_extra != 0) begin
            n_fail++;
            $display("FAIL blank_rgb_or_fs got bad_rgb=%0d fs=%0d want 0 0", bad_blank, fs_extra);
        end
    endtask

    // One-clock reset of A in the middle of an active line (h=300, v=46).
    task automatic test_mid_reset();
        @(posedge clk); #1 rst_a = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({de_a, r_a, g_a, b_a, fs_a} !== {1'b1, 12'hF00, 1'b0}) begin
            n_fail++;
            $display("FAIL pre_reset_pixel got de=%b rgb=%h fs=%b want de=1 rgb=f00 fs=0",
                     de_a, {r_a, g_a, b_a}, fs_a);
        end
        @(posedge clk); #1 rst_a = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({r_a, g_a, b_a, de_a, hs_a, vs_a, fs_a, ifa.req_valid} !== {12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_pins got rgb=%h de=%b hs=%b vs=%b fs=%b vld=%b want 000 0 1 1 1 0",
                     {r_a, g_a, b_a}, de_a, hs_a, vs_a, fs_a, ifa.req_valid);
        end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({de_a, r_a, g_a, b_a} !== {1'b0, 12'h000}) begin
                n_fail++;
                $display("FAIL stale_pixel_%0d got de=%b rgb=%h want de=0 rgb=000", i, de_a, {r_a, g_a, b_a});
            end
        end
    endtask

    // Instance B: lookup latency 2, frame pacing, small-raster corners.
    task automatic test_lookup_lat2();
        int cyc = 0, fs_cnt = 0, fs_first = -1, fs_last = -1;
        int hs_fall1 = -1, hs_fall2 = -1, vs_fall1 = -1, vs_low = 0, de_cnt = 0, snake_cnt = 0;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        @(posedge clk); #1 rst_b = 1'b0;
        @(negedge clk);
        n_tests++;
        if (fs_b !== 1'b1) begin
            n_fail++;
            $display("FAIL b_frame_start0 got %b want 1", fs_b);
        end
        while (cyc < 241) begin
            @(negedge clk);
            cyc++;
            if (fs_b) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = cyc;
                fs_last = cyc;
            end
            if (prev_hs && !hs_b) begin
                if (hs_fall1 < 0) hs_fall1 = cyc;
                else if (hs_fall2 < 0) hs_fall2 = cyc;
            end
            if (prev_vs && !vs_b && vs_fall1 < 0) vs_fall1 = cyc;
            prev_hs = hs_b;
            prev_vs = vs_b;
            if (!vs_b && cyc < 120) vs_low++;
            if (de_b && cyc >= 3 && cyc < 123) de_cnt++;
            if (de_b && {r_b, g_b, b_b} == 12'h0F0) snake_cnt++;
            if (cyc == 66 || cyc == 67 || cyc == 119) begin
                logic [20:0] want;
                want = (cyc == 66) ? {1'b0, 10'd0, 10'd0} :
                       (cyc == 67) ? {1'b1, 10'd0, 10'd0} : {1'b1, 10'd7, 10'd3};
                n_tests++;
                if ({ifb.req_valid, ifb.curr_x, ifb.curr_y} !== want) begin
                    n_fail++;
                    $display("FAIL b_coord_c%0d got vld=%b x=%0d y=%0d want vld=%b x=%0d y=%0d", cyc,
                             ifb.req_valid, ifb.curr_x, ifb.curr_y, want[20], want[19:10], want[9:0]);
                end
            end
            if (cyc >= 74 && cyc <= 76) begin
                logic [11:0] want_rgb;
                want_rgb = (cyc == 75) ? 12'h0F0 : 12'hFFF;
                n_tests++;
                if ({de_b, r_b, g_b, b_b} !== {1'b1, want_rgb}) begin
                    n_fail++;
                    $display("FAIL b_snake_c%0d got de=%b rgb=%h want de=1 rgb=%h", cyc, de_b,
                             {r_b, g_b, b_b}, want_rgb);
                end
            end
        end
        n_tests++;
        if (fs_cnt != 2 || fs_first != 120 || fs_last != 240) begin
            n_fail++;
            $display("FAIL b_frame_period got cnt=%0d first=%0d last=%0d want 2 120 240", fs_cnt, fs_first, fs_last);
        end
        n_tests++;
        if (hs_fall1 != 5 || hs_fall2 != 20) begin
            n_fail++;
            $display("FAIL b_hs got fall1=%0d fall2=%0d want 5 20", hs_fall1, hs_fall2);
        end
        n_tests++;
        if (vs_fall1 != 18 || vs_low != 30) begin
            n_fail++;
            $display("FAIL b_vs got fall=%0d low=%0d want 18 30", vs_fall1, vs_low);
        end
        n_tests++;
        if (de_cnt != 32 || snake_cnt != 2) begin
            n_fail++;
            $display("FAIL b_de_snake got de=%0d snake=%0d want 32 2", de_cnt, snake_cnt);
        end
    endtask

    // Instance C: active-high syncs, zero lookup latency.
    task automatic test_active_high_sync();
        int cyc = 0, hs_rise = -1, hs_high = 0, vs_rise = -1, vs_high = 0;
        logic prev_hs = 1'b0, prev_vs = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({hs_c, vs_c, de_c} !== 3'b000) begin
            n_fail++;
            $display("FAIL c_reset_syncs got hs=%b vs=%b de=%b want 0 0 0", hs_c, vs_c, de_c);
        end
        @(posedge clk); #1 rst_c = 1'b0;
        @(negedge clk);
        n_tests++;
        if (fs_c !== 1'b1) begin
            n_fail++;
            $display("FAIL c_frame_start0 got %b want 1", fs_c);
        end
        while (cyc < 3365) begin
            @(negedge clk);
            cyc++;
            if (!prev_hs && hs_c && hs_rise < 0) hs_rise = cyc;
            if (!prev_vs && vs_c && vs_rise < 0) vs_rise = cyc;
            prev_hs = hs_c;
            prev_vs = vs_c;
            if (hs_c && cyc < 800) hs_high++;
            if (vs_c) vs_high++;
            if (cyc >= 3360 && cyc <= 3362) begin
                logic [12:0] want;
                want = (cyc == 3360) ? {1'b0, 12'h000} :
                       (cyc == 3361) ? {1'b1, 12'hF00} : {1'b1, 12'h00F};
                n_tests++;
                if ({de_c, r_c, g_c, b_c} !== want) begin
                    n_fail++;
                    $display("FAIL c_lat0_c%0d got de=%b rgb=%h want de=%b rgb=%h", cyc, de_c,
                             {r_c, g_c, b_c}, want[12], want[11:0]);
                end
            end
        end
        n_tests++;
        if (hs_rise != 17 || hs_high != 96) begin
            n_fail++;
            $display("FAIL c_hs_high got rise=%0d high=%0d want 17 96", hs_rise, hs_high);
        end
        n_tests++;
        if (vs_rise != 801 || vs_high != 1600) begin
            n_fail++;
            $display("FAIL c_vs_high got rise=%0d high=%0d want 801 1600", vs_rise, vs_high);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_mid_reset();
        test_lookup_lat2();
        test_active_high_sync();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
